// File: rtl/seg_pkg.sv
// seg_pkg: shared codes, segment patterns and the 16-entry decode table
package seg_pkg;
  localparam logic [3:0] CODE_BLANK = 4'd10;
  localparam logic [3:0] CODE_MINUS = 4'd11;
  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [6:0] SEG_MINUS  = 7'h3F;
  // active-low g..a; entry 15 first, entry 0 last
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF, SEG_MINUS, SEG_OFF,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/seg_decode.sv
// seg_decode: combinational digit code to active-low segment pattern
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);
  assign pattern = SEG_TABLE[code];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit multiplexed 7-segment scanner with tear-free update and blink
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dig6,
  input  logic [3:0] dig4,
  input  logic [3:0] dig2,
  input  logic [3:0] dig1,
  input  logic       load,
  input  logic [3:0] blink_mask,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_tick
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [PW-1:0]   presc;
  logic [1:0]      idx;
  logic [BW-1:0]   bcnt;
  logic            phase;
  logic [3:0]      mask_q;
  logic [3:0][3:0] pend, disp;
  logic [15:0]     din;
  logic            slot_end, wrap;
  logic [3:0]      code;
  logic [6:0]      pat;
  assign din      = {dig6, dig4, dig2, dig1};
  assign slot_end = presc == PW'(SCAN_DIV - 1);
  assign wrap     = slot_end && idx == 2'd3;
  assign code     = (phase && mask_q[idx]) ? CODE_BLANK : disp[idx];
  seg_decode u_dec (.code(code), .pattern(pat));
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      bcnt       <= '0;
      phase      <= 1'b0;
      mask_q     <= '0;
      frame_tick <= 1'b0;
      an         <= 4'hF;
      seg        <= SEG_OFF;
      pend       <= {4{CODE_BLANK}};
      disp       <= {4{CODE_BLANK}};
    end else begin
      presc      <= slot_end ? '0 : presc + 1'b1;
      frame_tick <= wrap;
      an         <= (presc < PW'(2)) ? 4'hF : ~(4'b0001 << idx);
      seg        <= pat;
      if (slot_end) begin
        idx    <= idx + 2'd1;
        mask_q <= blink_mask;
      end
      if (load) pend <= din;
      // a load on the wrap edge bypasses pending so the new frame shows it
      if (wrap) begin
        disp  <= load ? din : pend;
        bcnt  <= (bcnt == BW'(BLINK_FRAMES - 1)) ? '0 : bcnt + 1'b1;
        phase <= (bcnt == BW'(BLINK_FRAMES - 1)) ? ~phase : phase;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: random and directed stimulus against a cycle-count reference model
module tb_seg_scan_driver;
  logic       clk = 0;
  logic       rst, load;
  logic [3:0] dig6, dig4, dig2, dig1, blink_mask;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_tick;
  int vectors = 0, errors = 0;
  seg_scan_driver #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .dig6(dig6), .dig4(dig4), .dig2(dig2), .dig1(dig1),
    .load(load), .blink_mask(blink_mask), .seg(seg), .an(an), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [6:0] ref_seg(input logic [3:0] c);
    case (c)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; 9: return 7'h10; 11: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction
  // model: everything derived from t, the number of edges since reset release
  int t, p, s, f;
  bit armed = 0;
  logic [3:0] pend [4], disp [4], meff;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_tick;
  always @(posedge clk) begin
    armed = 1;
    if (rst) begin
      t = 0; meff = 0; e_an = 4'hF; e_seg = 7'h7F; e_tick = 0;
      pend = '{4'd10, 4'd10, 4'd10, 4'd10};
      disp = '{4'd10, 4'd10, 4'd10, 4'd10};
    end else begin
      p = t % 4; s = (t / 4) % 4; f = t / 16;
      e_an   = (p < 2) ? 4'hF : ~(4'b0001 << s);
      e_seg  = (((f / 2) % 2) == 1 && meff[s]) ? 7'h7F : ref_seg(disp[s]);
      e_tick = (p == 3 && s == 3);
      if (load) pend = '{dig1, dig2, dig4, dig6};
      if (e_tick) disp = pend;
      if (p == 3) meff = blink_mask;
      t++;
    end
  end
  always @(negedge clk) if (armed) begin
    chk("an", an, e_an);
    chk("seg", seg, e_seg);
    chk("frame_tick", frame_tick, e_tick);
  end
  task automatic pulse_load(input logic [3:0] a, b, c, d);
    {dig6, dig4, dig2, dig1} = {a, b, c, d};
    load = 1;
    @(negedge clk) load = 0;
  endtask
  initial begin
    int ticks;
    rst = 1; load = 0; blink_mask = 0; {dig6, dig4, dig2, dig1} = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) chk("an_first_lit", an, 4'b1110);
    pulse_load(1, 2, 11, 5);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 16 && (t / 4) % 4 != 2; i++) @(negedge clk);
    @(negedge clk) pulse_load(9, 9, 9, 9);
    ticks = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ticks += int'(frame_tick);
    end
    chk("tick_count", ticks, 2);
    for (int i = 0; i < 16 && t % 16 != 15; i++) @(negedge clk);
    pulse_load(3, 0, 7, 8);
    repeat (20) @(negedge clk);
    blink_mask = 4'b0001;
    repeat (140) @(negedge clk);
    for (int i = 0; i < 16 && (t / 4) % 4 != 2; i++) @(negedge clk);
    rst = 1; load = 1;
    repeat (2) @(negedge clk);
    rst = 0; load = 0;
    pulse_load(4, 11, 6, 14);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 700; i++) begin
      {dig6, dig4, dig2, dig1} = 16'($urandom);
      load = ($urandom_range(7) == 0);
      if ($urandom_range(15) == 0) blink_mask = 4'($urandom);
      rst = ($urandom_range(199) == 0);
      @(negedge clk);
    end
    rst = 0; load = 0;
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit slot, minimum 4.
REQ-002 The block SHALL have parameter BLINK_FRAMES, default 64: full scan frames per blink phase, minimum 1.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is rising-edge clocked.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 Ports dig6, dig4, dig2, dig1, input, 4 bits each: digit codes from the calculator stage; 0-9 are numerals, 10 is blank, 11 is minus, 12-15 are treated as blank.
REQ-006 Port load, input, 1 bit: single-cycle strobe meaning "sample digit inputs now".
REQ-007 Port blink_mask, input, 4 bits: bit i=1 makes slot i blink.
REQ-008 Port seg, output, 7 bits: segments g..a (bit6=g, bit0=a), active-low.
REQ-009 Port an, output, 4 bits: digit anodes, active-low, one-hot-low when lit; an[3]=dig6, an[2]=dig4, an[1]=dig2, an[0]=dig1.
REQ-010 Port frame_tick, output, 1 bit: one-cycle pulse at each frame wrap.

Function
REQ-011 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; its terminal count SHALL advance slot index 0->1->2->3->0.
REQ-012 Slot index 0 SHALL select dig1/an[0], 1 dig2/an[1], 2 dig4/an[2], 3 dig6/an[3].
REQ-013 On load=1, digit inputs SHALL be captured into pending registers on that clock edge; a later load before frame wrap SHALL overwrite pending.
REQ-014 Pending registers SHALL transfer to display registers only at frame wrap (index 3->0), so a frame never mixes old and new digits.
REQ-015 If load and frame wrap coincide, the newly sampled values SHALL go directly to display registers for the new frame.
REQ-016 frame_tick SHALL be 1 for exactly the cycle in which index is 0 and the prescaler is 0 after a wrap; it SHALL NOT pulse at the first frame after reset.
REQ-017 Dead time: for prescaler values 0 and 1 of every slot, an SHALL be 4'b1111; for values 2..SCAN_DIV-1, an SHALL drive the current slot low.
REQ-018 seg SHALL be the registered decode of the current slot's display code; numeral patterns are standard, 10/12-15 give 7'h7F, and 11 gives 7'h3F (g only lit).
REQ-019 seg and an SHALL be registered outputs with 1-cycle latency from the index/prescaler state.
REQ-020 A blink counter SHALL count frame wraps and toggle blink_phase every BLINK_FRAMES wraps.
REQ-021 While blink_phase=1, slots with blink_mask set SHALL output the blank pattern; their anodes are still driven.
REQ-022 Changing blink_mask SHALL take effect on the next slot boundary and SHALL NOT reset the blink counter.
REQ-023 The prescaler, blink counter and index SHALL wrap cleanly with no off-by-one: one frame is exactly 4*SCAN_DIV cycles.

Reset
REQ-024 While rst=1, the following SHALL be held on every clk edge: prescaler=0, index=0, blink counter=0, blink_phase=0, frame_tick=0, an=4'b1111, seg=7'h7F.
REQ-025 While rst=1, pending and display registers SHALL be set to code 10 (blank), and load SHALL be ignored.
REQ-026 Reset asserted mid-frame SHALL discard pending data; the first frame after release SHALL start at index 0 with prescaler 0.

Structure
REQ-027 Shared package seg_pkg SHALL hold CODE_BLANK=10, CODE_MINUS=11, SEG_OFF=7'h7F, SEG_MINUS=7'h3F and the 16-entry decode table.
REQ-028 Decode SHALL be a combinational sub-module seg_decode (4-bit code in, 7-bit active-low pattern out); all sequencing stays in seg_scan_driver.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-029 Reset check: hold rst 3 cycles, then release -> an=1111 and seg=7F throughout reset; first lit slot is an=1110 at cycle 3 after release.
REQ-030 Scan order: load dig6=1, dig4=2, dig2=11, dig1=5 -> from the next frame an cycles 1110, 1101, 1011, 0111 with seg 12 (5), 3F (minus), 24 (2), 79 (1).
REQ-031 Tear-free update: pulse load with 9,9,9,9 mid-slot-2 -> the remainder of the frame keeps old digits; all slots show 10 (9) from the next frame; frame_tick pulses once per 16 cycles.
REQ-032 Coincident load at wrap: load=1 on the wrap cycle -> the new digits are displayed in the immediately following frame.
REQ-033 Blink: blink_mask=0001 -> slot 0 seg=7F in frames 2-3, 6-7, ...; other slots are unaffected.
REQ-034 Reset mid-operation plus invalid codes: assert rst during slot 2 -> blank output from the next edge; after release with dig1=14, slot 0 seg=7F.
